// File: rtl/csr_txn_pkg.sv
// CSR transaction capture: shared types and widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package csr_txn_pkg;

    localparam int CsrAddrW = 12;
    localparam int CsrDataW = 32;
    localparam int SeqW     = 32;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef struct packed {
        csr_op_e               op;
        logic [CsrAddrW-1:0]   addr;
        logic [CsrDataW-1:0]   wdata;
        logic [CsrDataW-1:0]   rdata;
        logic                  illegal;
        logic [SeqW-1:0]       seq;
    } csr_txn_t;

endpackage

// File: rtl/csr_txn_capture_if.sv
// Captured-transaction output stream: head entry plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: consumer holds txn_ready_i low to stall; producer keeps txn_o stable.
interface csr_txn_capture_if;
    import csr_txn_pkg::*;

    logic     txn_valid_o;
    logic     txn_ready_i;
    csr_txn_t txn_o;

    modport master (
        output txn_valid_o,
        output txn_o,
        input  txn_ready_i
    );

    modport slave (
        input  txn_valid_o,
        input  txn_o,
        output txn_ready_i
    );

endinterface

// File: rtl/csr_txn_fifo.sv
// Generic FIFO: Depth entries of entry_t, head read straight from registered storage.
// Latency: 1 cycle from push to head_vld; no input-to-head combinational path.
// Backpressure: caller must only push when !full or when popping in the same cycle.
module csr_txn_fifo #(
    parameter int  Depth   = 4,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  entry_t push_dat,
    input  logic   pop,
    output logic   full,
    output logic   head_vld,
    output entry_t head_dat
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = PtrW + 1;

    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    entry_t          mem [Depth];

    logic do_pop;

    assign head_vld = (count != '0);
    assign full     = (count == CntW'(Depth));
    assign do_pop   = pop && head_vld;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap naturally because Depth is a power of two; occupancy
    // is unchanged when a push and a pop land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; its contents are only observed under head_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/csr_txn_capture.sv
// Captures every CSR access into a FIFO of csr_txn_t with a running sequence number.
// Latency: 1 cycle from the access edge to txn_valid_o.
// Backpressure: txn_ready_i low stalls the head; captures into a full buffer without a pop are dropped and counted.
module csr_txn_capture
    import csr_txn_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                csr_access_i,
    input  logic [1:0]          csr_op_i,
    input  logic [CsrAddrW-1:0] csr_addr_i,
    input  logic [CsrDataW-1:0] csr_wdata_i,
    input  logic [CsrDataW-1:0] csr_rdata_i,
    input  logic                illegal_csr_i,
    input  logic                clear_i,
    csr_txn_capture_if.master   txn_if,
    output logic                overflow_o,
    output logic [15:0]         drop_cnt_o
);

    logic            fifo_full;
    logic            head_vld;
    csr_txn_t        head_dat;
    csr_txn_t        cap_entry;
    logic            pop;
    logic            push;
    logic            drop;
    logic [SeqW-1:0] seq;

    // A pop frees a slot on the same edge, so a full buffer still accepts
    // a capture that coincides with the consumer taking the head.
    assign pop  = head_vld && txn_if.txn_ready_i;
    assign push = csr_access_i && (!fifo_full || pop);
    assign drop = csr_access_i && fifo_full && !pop;

    // Assemble the entry from this cycle's CSR inputs and the current sequence number.
    always_comb begin
        cap_entry         = '0;
        cap_entry.op      = csr_op_e'(csr_op_i);
        cap_entry.addr    = csr_addr_i;
        cap_entry.wdata   = csr_wdata_i;
        cap_entry.rdata   = csr_rdata_i;
        cap_entry.illegal = illegal_csr_i;
        cap_entry.seq     = seq;
    end

    // Sequence number advances only for captures that actually enter the buffer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq <= '0;
        end else if (push) begin
            seq <= seq + 1'b1;
        end
    end

    // Sticky overflow and saturating drop count; clear takes priority over a coincident drop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 16'hFFFF) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    csr_txn_fifo #(
        .Depth   (Depth),
        .entry_t (csr_txn_t)
    ) u_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (push),
        .push_dat (cap_entry),
        .pop      (pop),
        .full     (fifo_full),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    assign txn_if.txn_valid_o = head_vld;
    assign txn_if.txn_o       = head_dat;

endmodule

// File: tb/tb_csr_txn_capture.sv
// Scoreboard bench for csr_txn_capture: directed captures, monitor pops and compares.
// Latency: expects entries one cycle after the capture edge.
// Backpressure: bench toggles txn_ready_i to exercise stall, overflow and full push/pop.
module tb_csr_txn_capture;
    import csr_txn_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                csr_access = 1'b0;
    logic [1:0]          csr_op = 2'd0;
    logic [CsrAddrW-1:0] csr_addr = '0;
    logic [CsrDataW-1:0] csr_wdata = '0;
    logic [CsrDataW-1:0] csr_rdata = '0;
    logic                illegal_csr = 1'b0;
    logic                clear = 1'b0;
    logic                overflow;
    logic [15:0]         drop_cnt;

    csr_txn_capture_if txn_if ();

    csr_txn_capture #(.Depth(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .csr_access_i  (csr_access),
        .csr_op_i      (csr_op),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_i   (csr_rdata),
        .illegal_csr_i (illegal_csr),
        .clear_i       (clear),
        .txn_if        (txn_if),
        .overflow_o    (overflow),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_err = 0;
    csr_txn_t exp_q[$];
    csr_txn_t held;
    bit       hold_chk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted head against the scoreboard and
    // check that a stalled head does not change.
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_chk && txn_if.txn_valid_o) begin
                n_cmp++;
                if (txn_if.txn_o !== held) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h expected %h", txn_if.txn_o, held);
                end
            end
            if (txn_if.txn_valid_o && txn_if.txn_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pop: got seq %h expected no entry", txn_if.txn_o.seq);
                end else begin
                    csr_txn_t e;
                    e = exp_q.pop_front();
                    if (txn_if.txn_o !== e) begin
                        n_err++;
                        $display("FAIL entry: got op=%0d addr=%h wd=%h rd=%h ill=%b seq=%h expected op=%0d addr=%h wd=%h rd=%h ill=%b seq=%h",
                                 txn_if.txn_o.op, txn_if.txn_o.addr, txn_if.txn_o.wdata, txn_if.txn_o.rdata,
                                 txn_if.txn_o.illegal, txn_if.txn_o.seq,
                                 e.op, e.addr, e.wdata, e.rdata, e.illegal, e.seq);
                    end
                end
            end
            hold_chk = txn_if.txn_valid_o && !txn_if.txn_ready_i;
            held     = txn_if.txn_o;
        end else begin
            hold_chk = 1'b0;
        end
    end

    // One capture cycle; called at posedge+1, returns at the following posedge+1.
    task automatic cap(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic ill, input bit accepted, input logic [31:0] s);
        csr_txn_t e;
        csr_access  = 1'b1;
        csr_op      = op;
        csr_addr    = addr;
        csr_wdata   = wd;
        csr_rdata   = rd;
        illegal_csr = ill;
        if (accepted) begin
            e.op      = csr_op_e'(op);
            e.addr    = addr;
            e.wdata   = wd;
            e.rdata   = rd;
            e.illegal = ill;
            e.seq     = s;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        csr_access = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, txn_if.txn_valid_o}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        txn_if.txn_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        txn_if.txn_ready_i = 1'b0;
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d entries left expected 0", exp_q.size());
            exp_q.delete();
        end
        chk("drained_valid", {31'd0, txn_if.txn_valid_o}, 32'd0);
    endtask

    initial begin
        txn_if.txn_ready_i = 1'b0;

        // Single capture: no same-cycle bypass, visible one cycle later, then popped.
        do_reset();
        csr_access = 1'b1;
        csr_op     = 2'd1;
        csr_addr   = 12'h300;
        csr_wdata  = 32'h8;
        csr_rdata  = 32'h1800;
        begin
            csr_txn_t e;
            e = '{op: CSR_WRITE, addr: 12'h300, wdata: 32'h8, rdata: 32'h1800, illegal: 1'b0, seq: 32'd0};
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("no_bypass_valid", {31'd0, txn_if.txn_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        csr_access = 1'b0;
        chk("latency1_valid", {31'd0, txn_if.txn_valid_o}, 32'd1);
        chk("latency1_seq", txn_if.txn_o.seq, 32'd0);
        drain();

        // Back-to-back: four captures held, popped in order seq 0..3.
        do_reset();
        cap(2'd0, 12'h340, 32'h0, 32'hA0, 1'b0, 1'b1, 32'd0);
        cap(2'd1, 12'h341, 32'h1, 32'hA1, 1'b0, 1'b1, 32'd1);
        cap(2'd2, 12'h342, 32'h2, 32'hA2, 1'b1, 1'b1, 32'd2);
        cap(2'd3, 12'h343, 32'h3, 32'hA3, 1'b0, 1'b1, 32'd3);
        chk("b2b_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        drain();

        // Overflow: six captures into depth 4, two dropped, next accepted gets seq 4.
        do_reset();
        cap(2'd1, 12'h100, 32'h10, 32'h0, 1'b0, 1'b1, 32'd0);
        cap(2'd1, 12'h101, 32'h11, 32'h0, 1'b0, 1'b1, 32'd1);
        cap(2'd1, 12'h102, 32'h12, 32'h0, 1'b0, 1'b1, 32'd2);
        cap(2'd1, 12'h103, 32'h13, 32'h0, 1'b0, 1'b1, 32'd3);
        cap(2'd1, 12'h104, 32'h14, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("ovf_first_drop", {31'd0, overflow}, 32'd1);
        cap(2'd1, 12'h105, 32'h15, 32'h0, 1'b0, 1'b0, 32'd0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd2);
        drain();
        cap(2'd2, 12'h106, 32'h16, 32'h5, 1'b1, 1'b1, 32'd4);
        drain();
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_overflow", {31'd0, overflow}, 32'd0);
        chk("clear_drop_cnt", {16'd0, drop_cnt}, 32'd0);

        // Full with simultaneous pop: capture accepted, still full, new entry last out.
        do_reset();
        cap(2'd0, 12'h200, 32'h0, 32'h20, 1'b0, 1'b1, 32'd0);
        cap(2'd0, 12'h201, 32'h0, 32'h21, 1'b0, 1'b1, 32'd1);
        cap(2'd0, 12'h202, 32'h0, 32'h22, 1'b0, 1'b1, 32'd2);
        cap(2'd0, 12'h203, 32'h0, 32'h23, 1'b0, 1'b1, 32'd3);
        txn_if.txn_ready_i = 1'b1;
        cap(2'd3, 12'h204, 32'hFF, 32'h24, 1'b0, 1'b1, 32'd4);
        txn_if.txn_ready_i = 1'b0;
        chk("pp_no_drop", {16'd0, drop_cnt}, 32'd0);
        cap(2'd0, 12'h205, 32'h0, 32'h25, 1'b0, 1'b0, 32'd0);
        chk("pp_still_full", {16'd0, drop_cnt}, 32'd1);
        drain();

        // Reset mid-stream: buffered entries vanish at once, seq restarts at 0.
        do_reset();
        cap(2'd1, 12'h3A0, 32'h1, 32'h0, 1'b0, 1'b1, 32'd0);
        cap(2'd1, 12'h3A1, 32'h2, 32'h0, 1'b0, 1'b1, 32'd1);
        cap(2'd1, 12'h3A2, 32'h3, 32'h0, 1'b0, 1'b1, 32'd2);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_valid", {31'd0, txn_if.txn_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cap(2'd0, 12'h3A3, 32'h4, 32'h77, 1'b0, 1'b1, 32'd0);
        drain();

        // Clear coinciding with a drop: clear wins.
        do_reset();
        cap(2'd0, 12'h010, 32'h0, 32'h1, 1'b0, 1'b1, 32'd0);
        cap(2'd0, 12'h011, 32'h0, 32'h2, 1'b0, 1'b1, 32'd1);
        cap(2'd0, 12'h012, 32'h0, 32'h3, 1'b0, 1'b1, 32'd2);
        cap(2'd0, 12'h013, 32'h0, 32'h4, 1'b0, 1'b1, 32'd3);
        cap(2'd0, 12'h014, 32'h0, 32'h5, 1'b0, 1'b0, 32'd0);
        chk("coll_pre_cnt", {16'd0, drop_cnt}, 32'd1);
        clear = 1'b1;
        cap(2'd0, 12'h015, 32'h0, 32'h6, 1'b0, 1'b0, 32'd0);
        clear = 1'b0;
        chk("coll_overflow", {31'd0, overflow}, 32'd0);
        chk("coll_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        drain();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
